// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the instruction fetch stage    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_t;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_unit_if: memory, decode and redirect signals of fetch  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface instruction_fetch_unit_if;
  logic [31:0] imem_address;
  logic [31:0] machine_code;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output imem_address,
    output inst_out,
    output pc_out,
    output pc_plus4_out,
    output inst_valid,
    input  machine_code,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_target
  );

  modport slave (
    input  imem_address,
    input  inst_out,
    input  pc_out,
    input  pc_plus4_out,
    input  inst_valid,
    output machine_code,
    output inst_ready,
    output redirect_valid,
    output redirect_target
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_register: program counter with hold / +4 / redirect next-PC select    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_t     pc_sel,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_q,
  output logic        target_misaligned
);

  logic [31:0] pc_d;

  assign target_misaligned = is_misaligned(redirect_target[1:0]);

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:      pc_d = pc_q + 32'(INST_BYTES);
      PC_REDIRECT: pc_d = redirect_target;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_unit: PC + one-entry fetch register with valid/ready  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  instruction_fetch_unit_if.master  bus,
  output logic                      fault,
  output logic [31:0]               fault_pc,
  output logic [31:0]               fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * INST_BYTES);

  fetch_state_t state_q, state_d;
  pc_sel_t      pc_sel;
  logic [31:0]  pc_q;
  logic         target_misaligned;

  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic [31:0]  count_q, count_d;
  logic         handshake;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_sel            (pc_sel),
    .redirect_target   (bus.redirect_target),
    .pc_q              (pc_q),
    .target_misaligned (target_misaligned)
  );

  assign handshake = valid_q & bus.inst_ready;

  always_comb begin
    state_d    = state_q;
    pc_sel     = PC_HOLD;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    // A handshake completing alongside a redirect or halt still counts.
    count_d    = count_q + 32'(handshake);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
          inst_d  = NOP_INSN;
          if (target_misaligned) begin
            state_d    = HALT;
            fault_d    = 1'b1;
            fault_pc_d = bus.redirect_target;
          end else begin
            pc_sel = PC_REDIRECT;
          end
        end else if (pc_q >= PC_LIMIT) begin
          state_d    = HALT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          valid_d    = 1'b0;
          inst_d     = NOP_INSN;
        end else if (!valid_q || handshake) begin
          inst_d   = bus.machine_code;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_sel   = PC_INC;
        end
      end

      HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inst_q     <= 32'h0;
      pc_out_q   <= 32'h0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_address = pc_q;
  assign bus.inst_out     = inst_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.pc_plus4_out = pc_out_q + 32'(INST_BYTES);
  assign bus.inst_valid   = valid_q;
  assign fault            = fault_q;
  assign fault_pc         = fault_pc_q;
  assign fetch_count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instruction_fetch_unit: directed vectors and corner-case sequences    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h1234_50b7;
    return 32'hA000_0000 | a;
  endfunction

  assign bus.machine_code = mem_word(bus.imem_address);

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    start = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
    logic [31:0] eimem;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] last_pc;
    logic [31:0] next_pc;
    int          seq_err;
    bit          saw_fault;

    vt[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'd0, 32'h04};
    vt[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'd1, 32'h08};
    vt[2] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 32'h0C};
    vt[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 32'h0C};
    vt[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 32'h0C};
    vt[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'd2, 32'h0C};
    vt[6] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'd3, 32'h10};
    vt[7] = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h00, 32'd4, 32'h40};
    vt[8] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'd4, 32'h44};
    vt[9] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 32'd4, 32'h44};

    rst_n = 1'b1;
    start = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_valid",    32'(bus.inst_valid), 32'h0);
    check("rst_inst",     bus.inst_out,        32'h0);
    check("rst_pc_out",   bus.pc_out,          32'h0);
    check("rst_plus4",    bus.pc_plus4_out,    32'h4);
    check("rst_fault",    32'(fault),          32'h0);
    check("rst_fault_pc", fault_pc,            32'h0);
    check("rst_count",    fetch_count,         32'h0);
    check("rst_imem",     bus.imem_address,    32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h20;
    step();
    bus.redirect_valid  = 1'b0;
    check("idle_ignores_redirect", bus.imem_address, 32'h0);
    step();
    check("idle_no_valid", 32'(bus.inst_valid), 32'h0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_edge_no_valid", 32'(bus.inst_valid), 32'h0);

    for (int i = 0; i < 10; i++) begin
      bus.inst_ready      = vt[i].ready;
      bus.redirect_valid  = vt[i].rv;
      bus.redirect_target = vt[i].rt;
      step();
      check($sformatf("vec%0d_valid", i), 32'(bus.inst_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        check($sformatf("vec%0d_pc_out", i), bus.pc_out,       vt[i].epc);
        check($sformatf("vec%0d_inst", i),   bus.inst_out,     mem_word(vt[i].epc));
        check($sformatf("vec%0d_plus4", i),  bus.pc_plus4_out, vt[i].epc + 32'h4);
      end
      check($sformatf("vec%0d_count", i), fetch_count,      vt[i].ecnt);
      check($sformatf("vec%0d_imem", i),  bus.imem_address, vt[i].eimem);
    end
    bus.redirect_valid = 1'b0;

    // Redirect while a stall holds pc_out=8: flush, one bubble, then target.
    restart();
    bus.inst_ready = 1'b1;
    step();
    step();
    step();
    check("rd_pre_pc_out", bus.pc_out, 32'h8);
    bus.inst_ready = 1'b0;
    step();
    check("rd_stall_pc_out", bus.pc_out, 32'h8);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h10;
    step();
    bus.redirect_valid = 1'b0;
    check("rd_bubble_valid", 32'(bus.inst_valid), 32'h0);
    check("rd_bubble_count", fetch_count, 32'd2);
    bus.inst_ready = 1'b1;
    step();
    check("rd_target_valid", 32'(bus.inst_valid), 32'h1);
    check("rd_target_pc",    bus.pc_out,          32'h10);
    check("rd_target_plus4", bus.pc_plus4_out,    32'h14);
    check("rd_target_inst",  bus.inst_out,        mem_word(32'h10));

    // Misaligned redirect halts and ignores everything until reset.
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h6;
    step();
    check("mis_fault",    32'(fault),          32'h1);
    check("mis_fault_pc", fault_pc,            32'h6);
    check("mis_valid",    32'(bus.inst_valid), 32'h0);
    start = 1'b1;
    bus.redirect_target = 32'h20;
    for (int i = 0; i < 4; i++) step();
    start = 1'b0;
    bus.redirect_valid = 1'b0;
    check("halt_sticky_fault",    32'(fault),          32'h1);
    check("halt_sticky_fault_pc", fault_pc,            32'h6);
    check("halt_sticky_valid",    32'(bus.inst_valid), 32'h0);
    rst_n = 1'b0;
    #1;
    check("halt_reset_fault", 32'(fault), 32'h0);

    // Sequential run off the end of memory.
    restart();
    bus.inst_ready = 1'b1;
    last_pc   = 32'hFFFF_FFFF;
    next_pc   = 32'h0;
    seq_err   = 0;
    saw_fault = 1'b0;
    for (int i = 0; i < 60 && !saw_fault; i++) begin
      step();
      if (fault) begin
        saw_fault = 1'b1;
      end else if (bus.inst_valid) begin
        if (bus.pc_out !== next_pc) seq_err++;
        last_pc = bus.pc_out;
        next_pc = next_pc + 32'h4;
      end
    end
    check("run_order_errors", 32'(seq_err),        32'h0);
    check("run_last_pc",      last_pc,             32'd124);
    check("run_fault",        32'(fault),          32'h1);
    check("run_fault_pc",     fault_pc,            32'd128);
    check("run_valid",        32'(bus.inst_valid), 32'h0);
    check("run_count",        fetch_count,         32'd32);

    // Asynchronous reset between edges drops the in-flight instruction.
    restart();
    bus.inst_ready = 1'b1;
    step();
    step();
    step();
    check("ar_pre_pc_out", bus.pc_out, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid",  32'(bus.inst_valid), 32'h0);
    check("ar_inst",   bus.inst_out,        32'h0);
    check("ar_pc_out", bus.pc_out,          32'h0);
    check("ar_plus4",  bus.pc_plus4_out,    32'h4);
    check("ar_count",  fetch_count,         32'h0);
    check("ar_imem",   bus.imem_address,    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("ar_resume_valid", 32'(bus.inst_valid), 32'h1);
    check("ar_resume_pc",    bus.pc_out,          32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Program-counter and fetch stage that sits directly upstream of the instruction memory. It drives the word address into the memory, captures the returned `machine_code` with its PC into a one-entry fetch register, and presents the pair to decode over a valid/ready handshake. It also accepts PC redirects for jumps and branches, and halts with a fault on misaligned or out-of-range fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `IMEM_DEPTH`, default 32: instruction memory depth in words; the legal fetch range is 0 to IMEM_DEPTH*4-4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  leaves IDLE; sampled only in IDLE.
- `imem_address`  out  32  fetch address to instruction memory; combinational copy of pc_q.
- `machine_code`  in  32  instruction word returned combinationally by instruction memory for `imem_address`.
- `inst_out`  out  32  registered instruction.
- `pc_out`  out  32  PC of `inst_out`.
- `pc_plus4_out`  out  32  `pc_out` + 4, the JAL/JALR link value.
- `inst_valid`  out  1  fetch register holds an instruction.
- `inst_ready`  in  1  decode accepts the instruction this cycle.
- `redirect_valid`  in  1  load a new PC.
- `redirect_target`  in  32  new PC.
- `fault`  out  1  sticky; asserted in HALT.
- `fault_pc`  out  32  offending address.
- `fetch_count`  out  32  instructions handed to decode, counted on `inst_valid & inst_ready`; wraps modulo 2^32.

## Operation
- States are IDLE, FETCH and HALT.
- On reset: state IDLE, pc_q=RESET_PC, `inst_valid`=0, `inst_out`=0, `pc_out`=0, `pc_plus4_out`=4, `fault`=0, `fault_pc`=0, `fetch_count`=0.
- **IDLE:**
  - `start`=1 moves to FETCH.
  - Redirects are ignored.
- **FETCH, per cycle, in priority order:**
  1. `redirect_valid`=1:
     - If `redirect_target[1:0]` is nonzero, go to HALT with `fault_pc`=target.
     - Otherwise pc_q<=target and `inst_valid`<=0, which flushes the fetch register.
     - A handshake completing in the same cycle still counts in `fetch_count`.
  2. pc_q >= IMEM_DEPTH*4: go to HALT, `fault_pc`=pc_q, nothing is captured, and the fetch register is cleared.
  3. The fetch register is empty, or `inst_valid & inst_ready`: capture {pc_q, machine_code}, set `inst_valid`<=1, pc_q<=pc_q+4.
  4. Otherwise (stall): pc_q and the fetch register hold unchanged.
- **HALT:**
  - `inst_valid`=0 and `fault`=1.
  - All inputs are ignored; exit only by reset.
- **Arithmetic:** PC add is 32-bit modulo 2^32. Wrap to 0 can only follow an out-of-range fault, so it is never fetched.
- **Output stability:** while `inst_valid`=1 and `inst_ready`=0, `inst_out` and `pc_out` are stable.

## Timing
- `imem_address` is combinational from pc_q; the memory read is combinational, so a fetch completes within one cycle.
- **Latency:** `start` sampled at edge N puts FETCH in place at N; the first `inst_valid`=1 appears after edge N+1 with `pc_out`=RESET_PC.
- **Throughput:** one instruction per cycle while `inst_ready`=1.
- **Redirect penalty:** the instruction at the target is valid two edges after the redirect is sampled; there is one bubble.
- **Reset mid-operation:** asynchronous. All outputs reach their reset values immediately, and the in-flight instruction is dropped.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, FETCH, HALT).
  - `INST_BYTES`=4.
  - `NOP_INSN`=32'h0000_0013.
- One sub-module, `pc_register`:
  - holds pc_q;
  - provides the next-PC select between hold, +4 and redirect;
  - flags misalignment.
- The top level holds the FSM, the fetch register and the counter.

## Test plan
- **Reset then start, `inst_ready`=1, memory word 1 = 32'h123450b7:**
  - `pc_out` sequence 0, 4, 8, ...
  - `inst_out` at `pc_out`=4 is 32'h123450b7.
  - `fetch_count` increments every cycle.
- **`inst_ready` low for 3 cycles with `pc_out`=8:** `inst_out`, `pc_out` and `imem_address`=12 are stable; after release the next `pc_out` is 12 with no instruction lost or duplicated.
- **Redirect to 32'h10 while a stall holds `pc_out`=8:** the held instruction is flushed, one bubble follows, then `pc_out`=32'h10 and `pc_plus4_out`=32'h14.
- **Redirect to 32'h0000_0006:** `fault`=1, `fault_pc`=6, `inst_valid`=0, and the block stays in HALT until `rst_n` is low.
- **Sequential run past address 124 (IMEM_DEPTH=32):** the last valid `pc_out` is 124, then `fault`=1 and `fault_pc`=128.
- **`rst_n` asserted mid-stream:** outputs go to their reset values asynchronously, and after `start` the fetch resumes at RESET_PC.
